shift_add_mul: RTL and testbench
================================

# shift_add_mul

Sequential 4x4 unsigned shift-and-add multiplier that sits directly downstream of the team's 4-bit ripple adder `add` (ports a, b, cin, sum, cout). It reuses that adder as its per-iteration add stage. It accepts two 4-bit operands on a start pulse, runs four add/shift iterations, and presents an 8-bit product with a one-cycle done strobe.

## Interface
- WIDTH, 4, operand width; only 4 is supported, and any other value fails elaboration.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- a  input  4  multiplicand, captured on an accepted start.
- b  input  4  multiplier, captured on an accepted start.
- busy  output  1  high while iterating (RUN).
- done  output  1  one-cycle strobe; product is valid from this cycle.
- product  output  8  unsigned a*b; held until the next result.

## Operation
- Internal registers:
  - M[3:0]: multiplicand.
  - A[3:0]: partial high accumulator.
  - Q[3:0]: multiplier/low product.
  - C: carry.
  - cnt[1:0]: iteration counter.
- FSM states: IDLE, RUN, DONE.
- Transitions:
  - IDLE, start=1 → RUN.
  - RUN, cnt==3 → DONE; otherwise stay in RUN with cnt+1.
  - DONE, start=1 → RUN.
  - DONE, start=0 → IDLE.
- Accepted start: M←a, Q←b, A←0, C←0, cnt←0.
- One RUN iteration:
  - Adder inputs are a=A, b=(Q[0] ? M : 0), cin=0.
  - {C,A,Q} ← {cout, sum, Q} >> 1, i.e. a logical right shift of the 9-bit concatenation.
- Entering DONE: product ← {A,Q} taken after the 4th shift. product changes at no other time except reset.
- start while in RUN is ignored; no queueing.
- No overflow is possible: the maximum is 15*15 = 225, which fits in 8 bits. Cout of the adder is always absorbed by the shift.
- Reset values: busy=0, done=0, product=8'h00, state IDLE, and M, A, Q, C, cnt all 0.
- Reset mid-operation: rst=1 at any edge aborts the run and applies the reset values at that edge. The aborted operation never asserts done.
- rst and start together: rst wins.

## Timing
- E0 is the edge that samples start=1 in IDLE/DONE. Operands are captured at E0 and must be stable only at E0.
- Edges E1..E4 each perform one iteration. busy=1 in the four cycles following E0..E3.
- At E4: state→DONE, product loads, done=1 for exactly the cycle after E4, busy=0.
- Latency from start edge to done: 4 cycles.
- If start=1 at E5, the next operation begins at E5. Back-to-back throughput is one product per 5 cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `mul_pkg`:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t.
  - localparam OP_W=4.
  - localparam PROD_W=8.
  - localparam ITERS=4.
- One sub-module: an instance of the existing `add` as the iteration adder, with cin tied to 0. The FSM, counter and shift register are local to shift_add_mul.

## Test plan
- Basic: a=13, b=11, start pulse → done exactly 5 edges after start (cycle after E4), product=143 (8'h8F), busy high for 4 cycles.
- Extremes: 15*15 → 225 (8'hE1); 0*9 → 0; 9*0 → 0; 1*15 → 15. Each produces exactly one done pulse.
- Ignored start: start re-asserted with a=2, b=2 during RUN of 7*6 → product=42, single done pulse, operands not replaced.
- Back-to-back: 5*3 then start held in the DONE cycle with 12*12 → product=15, then 144 five cycles later. Between them, product holds 15.
- Reset mid-run: rst at E2 of 10*10 → next cycle busy=0, done=0, product=0, no done afterwards. A new 3*4 after reset gives 12.
- Exhaustive random sweep: all 256 operand pairs, compared against a*b; zero mismatches, and a failure count reported at the end.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and sizes for the sequential shift-and-add multiplier.
// Imported by shift_add_mul.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    localparam int ITERS  = 4;

endpackage

// File: rtl/add.sv
// 4-bit adder with carry in/out.
// Used as the per-iteration add stage of shift_add_mul.
module add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] total;

    assign total       = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign {cout, sum} = total;

endmodule

// File: rtl/shift_add_mul.sv
// Sequential 4x4 unsigned shift-and-add multiplier.
// Start captures operands; four add/shift iterations; one-cycle done strobe.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH-1:0]     product
);

    if (WIDTH != OP_W) begin : g_width_check
        $error("shift_add_mul: only WIDTH=4 is supported");
    end

    mul_state_t        state_q, state_d;
    logic [OP_W-1:0]   m_q, m_d;
    logic [OP_W-1:0]   acc_q, acc_d;
    logic [OP_W-1:0]   q_q, q_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [PROD_W-1:0] prod_q, prod_d;

    logic [OP_W-1:0]   add_b;
    logic [OP_W-1:0]   add_sum;
    logic              add_cout;
    logic [OP_W-1:0]   acc_next;
    logic [OP_W-1:0]   q_next;

    assign add_b = q_q[0] ? m_q : '0;

    add u_add (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry lands in A[3] after the shift; the bit shifted into C is always
    // zero, so C is implicit rather than stored.
    assign acc_next = {add_cout, add_sum[OP_W-1:1]};
    assign q_next   = {add_sum[0], q_q[OP_W-1:1]};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_next;
                q_d   = q_next;
                if (cnt_q == 2'(ITERS - 1)) begin
                    state_d = DONE;
                    prod_d  = {acc_next, q_next};
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = prod_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul: directed table, corner sequences,
// and a full operand sweep.
module tb_shift_add_mul;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a_i;
    logic [3:0] b_i;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    shift_add_mul #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_i),
        .b       (b_i),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that
    // follows the done cycle, with the DUT back in IDLE.
    task automatic run_op(input logic [3:0] x, input logic [3:0] y,
                          input logic [7:0] exp, input string name);
        start = 1'b1;
        a_i   = x;
        b_i   = y;
        step();
        start = 1'b0;
        a_i   = 4'($urandom_range(15));
        b_i   = 4'($urandom_range(15));
        for (int i = 0; i < 4; i++) begin
            chk({name, " busy"}, 16'(busy), 16'd1);
            chk({name, " done_early"}, 16'(done), 16'd0);
            step();
        end
        chk({name, " done"}, 16'(done), 16'd1);
        chk({name, " busy_off"}, 16'(busy), 16'd0);
        chk({name, " product"}, 16'(product), 16'(exp));
        step();
        chk({name, " done_once"}, 16'(done), 16'd0);
        chk({name, " hold"}, 16'(product), 16'(exp));
    endtask

    initial begin
        int dones;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a_i    = 4'd0;
        b_i    = 4'd0;

        vecs[0] = '{4'd13, 4'd11, 8'd143};
        vecs[1] = '{4'd15, 4'd15, 8'd225};
        vecs[2] = '{4'd0,  4'd9,  8'd0};
        vecs[3] = '{4'd9,  4'd0,  8'd0};
        vecs[4] = '{4'd1,  4'd15, 8'd15};
        vecs[5] = '{4'd6,  4'd7,  8'd42};

        step();
        start = 1'b1;
        step();
        chk("reset busy", 16'(busy), 16'd0);
        chk("reset done", 16'(done), 16'd0);
        chk("reset product", 16'(product), 16'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk("idle busy", 16'(busy), 16'd0);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // start during RUN must not replace the operands
        start = 1'b1;
        a_i   = 4'd7;
        b_i   = 4'd6;
        step();
        a_i = 4'd2;
        b_i = 4'd2;
        step();
        step();
        start = 1'b0;
        step();
        step();
        chk("ign done", 16'(done), 16'd1);
        chk("ign product", 16'(product), 16'd42);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) dones++;
        end
        chk("ign single done", 16'(dones), 16'd0);

        // back-to-back: second start held in the DONE cycle
        start = 1'b1;
        a_i   = 4'd5;
        b_i   = 4'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        step();
        chk("b2b done1", 16'(done), 16'd1);
        chk("b2b product1", 16'(product), 16'd15);
        start = 1'b1;
        a_i   = 4'd12;
        b_i   = 4'd12;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("b2b busy2", 16'(busy), 16'd1);
            chk("b2b hold", 16'(product), 16'd15);
            step();
        end
        chk("b2b done2", 16'(done), 16'd1);
        chk("b2b product2", 16'(product), 16'd144);
        step();
        chk("b2b done2 once", 16'(done), 16'd0);

        // reset sampled at E2 aborts the run
        start = 1'b1;
        a_i   = 4'd10;
        b_i   = 4'd10;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort busy", 16'(busy), 16'd0);
        chk("abort done", 16'(done), 16'd0);
        chk("abort product", 16'(product), 16'd0);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dones++;
            step();
        end
        chk("abort no done", 16'(dones), 16'd0);
        run_op(4'd3, 4'd4, 8'd12, "after_reset");

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run_op(4'(x), 4'(y), 8'(x * y), $sformatf("sweep %0d*%0d", x, y));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
